thor2022_regfile_wb: RTL and testbench
======================================

Name: thor2022_regfile_wb

Overview:
- Architectural register file plus write-back scoreboard for the Thor2022 core.
- The Ra/Rb/Rc decoders produce 6-bit physical register indices. Stack-pointer remapping (31 -> 44..47) and link aliasing (29/30 -> 41/42) are already applied to those indices.
- This block is the other end of that path:
  - it serves the three read ports;
  - it accepts write-back;
  - it tracks pending destination writes so decode can stall on RAW/WAW hazards.
- Sits between decode/issue and the write-back stage.

Parameters:
- WID, 64, register data width in bits.
- NREGS, 48, number of physical registers (index 0..NREGS-1); reg 0 is hard zero.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous active-high reset.
- ra_i  input  6  read port A index (already remapped).
- rb_i  input  6  read port B index.
- rc_i  input  6  read port C index.
- ra_o  output WID  port A data.
- rb_o  output WID  port B data.
- rc_o  output WID  port C data.
- ra_busy_o  output 1  port A register has pending write.
- rb_busy_o  output 1  port B register has pending write.
- rc_busy_o  output 1  port C register has pending write.
- issue_v_i  input  1  instruction with destination issuing this cycle.
- issue_rt_i  input  6  destination index of issuing instruction.
- issue_rdy_o  output 1  issue accepted this cycle (no WAW conflict).
- wb_v_i  input  1  write-back valid.
- wb_rt_i  input  6  write-back destination index.
- wb_res_i  input  WID  write-back data.
- flush_i  input  1  pipeline flush; discard all pending writes.
- pending_o  output 6  count of registers currently marked busy.
- wb_err_o  output 1  sticky: write-back to a non-busy register seen.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_i is synchronous, active-high.
- On reset:
  - all registers are zeroed;
  - all busy bits are cleared;
  - pending_o = 0 and wb_err_o = 0.
  - Reset wins over every simultaneous event.
- Reads (combinational, zero latency):
  - Index 0 or index >= NREGS reads 0, and its busy output reads 0.
  - If wb_v_i is high and wb_rt_i equals the read index (nonzero, in range), the output is wb_res_i (bypass), and busy for that port reads 0.
  - Otherwise the output is the stored value, and busy reads busy[index].
- Write: on a clock edge with wb_v_i high and wb_rt_i in 1..NREGS-1:
  - regs[wb_rt_i] <= wb_res_i;
  - busy[wb_rt_i] is cleared.
  - Writes to index 0 or out-of-range indices are dropped silently; they set no error.
- Unsolicited write-back: wb_v_i to an in-range nonzero register whose busy bit is 0 still writes the data, and sets wb_err_o. wb_err_o stays set until reset.
- Issue handshake (issue_rdy_o is combinational):
  - issue_rdy_o = issue_v_i AND (issue_rt_i is 0 or out of range, OR busy[issue_rt_i]=0, OR (wb_v_i AND wb_rt_i==issue_rt_i)).
  - On an accepted issue with an in-range nonzero rt, busy[rt] is set at the edge.
  - Issue to index 0 or out of range is accepted but sets no bit.
  - When issue_v_i is low, issue_rdy_o is 0.
- Same-cycle write-back and issue to the same register: the write-back data is written, and the busy bit ends at 1 (the set takes priority over the clear).
- Flush:
  - All busy bits are cleared at the edge.
  - A write-back in the same cycle still writes its data.
  - An issue in the same cycle is ignored and no busy bit is set.
  - wb_err_o is unaffected.
- pending_o: registered population count of the busy vector, updated the cycle after every change. Maximum value is NREGS-1 (47).
- Register storage is a flop array, not inferred RAM, so that reset clears it.

Decomposition:
- Shared package Thor2022_pkg holds:
  - NREGS;
  - alias constants REG_LK1=41, REG_LK2=42, REG_SP0..REG_SP3=44..47;
  - typedef regno_t (6-bit).
- One sub-module, thor2022_scoreboard, owns:
  - the busy vector;
  - the set/clear/flush priority;
  - issue_rdy_o;
  - pending_o.
- The top level holds the data array, the bypass muxes and wb_err_o.

Test Plan:
- Reset then read: ra_i=0, rb_i=5, rc_i=47 -> all outputs 0, busy 0, pending_o=0.
- Issue then write-back: issue rt=7 (rdy=1).
  - Next cycle rb_i=7 -> rb_busy_o=1, pending_o=1.
  - wb rt=7 data 0x1234 -> same-cycle rb_o=0x1234 and rb_busy_o=0 (bypass).
  - Following cycle stored value is 0x1234 and pending_o=0.
- WAW stall: rt=44 busy.
  - Issue rt=44 -> issue_rdy_o=0.
  - Same cycle as wb rt=44 -> issue_rdy_o=1, and busy[44] stays 1 after the edge.
- Reg 0 and out of range:
  - wb rt=0 data 0xFF -> ra_i=0 still reads 0, wb_err_o=0.
  - Issue rt=50 -> rdy=1, pending_o unchanged.
- Flush: busy on regs 3, 41, 45.
  - flush_i with simultaneous wb rt=3 data 0xAA -> next cycle all busy 0, pending_o=0, reg 3 = 0xAA.
- Unsolicited write-back: wb rt=12 while not busy -> reg 12 updated, wb_err_o=1 and held; rst_i -> wb_err_o=0, reg 12 = 0.

Source files
------------

// File: rtl/thor2022_regfile_wb_pkg.sv
// rtl/thor2022_regfile_wb_pkg.sv - shared register numbering for the Thor2022 register file
package Thor2022_pkg;

   localparam int NREGS   = 48;
   localparam int REG_LK1 = 41;
   localparam int REG_LK2 = 42;
   localparam int REG_SP0 = 44;
   localparam int REG_SP1 = 45;
   localparam int REG_SP2 = 46;
   localparam int REG_SP3 = 47;

   typedef logic [5:0] regno_t;

   // Register 0 is hard zero and indices past NREGS do not exist.
   function automatic logic f_reg_ok(regno_t r);
      return (r != '0) && (int'(r) < NREGS);
   endfunction

   function automatic regno_t f_popcnt(logic [NREGS-1:0] v);
      regno_t cnt;
      cnt = '0;
      for (int i = 0; i < NREGS; i++)
         cnt = cnt + regno_t'(v[i]);
      return cnt;
   endfunction

endpackage

// File: rtl/thor2022_regfile_wb_if.sv
// rtl/thor2022_regfile_wb_if.sv - read, issue and write-back signals of the register file
interface thor2022_regfile_wb_if #(parameter int WID = 64);
   import Thor2022_pkg::*;

   regno_t           ra_i;
   regno_t           rb_i;
   regno_t           rc_i;
   logic [WID-1:0]   ra_o;
   logic [WID-1:0]   rb_o;
   logic [WID-1:0]   rc_o;
   logic             ra_busy_o;
   logic             rb_busy_o;
   logic             rc_busy_o;
   logic             issue_v_i;
   regno_t           issue_rt_i;
   logic             issue_rdy_o;
   logic             wb_v_i;
   regno_t           wb_rt_i;
   logic [WID-1:0]   wb_res_i;
   logic             flush_i;
   regno_t           pending_o;
   logic             wb_err_o;

   modport master (
      output ra_i, rb_i, rc_i, issue_v_i, issue_rt_i, wb_v_i, wb_rt_i, wb_res_i, flush_i,
      input  ra_o, rb_o, rc_o, ra_busy_o, rb_busy_o, rc_busy_o, issue_rdy_o, pending_o, wb_err_o
   );

   modport slave (
      input  ra_i, rb_i, rc_i, issue_v_i, issue_rt_i, wb_v_i, wb_rt_i, wb_res_i, flush_i,
      output ra_o, rb_o, rc_o, ra_busy_o, rb_busy_o, rc_busy_o, issue_rdy_o, pending_o, wb_err_o
   );

endinterface

// File: rtl/thor2022_regfile_wb_scoreboard.sv
// rtl/thor2022_regfile_wb_scoreboard.sv - busy tracking for pending destination writes
module thor2022_scoreboard
   import Thor2022_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             issue_v_i,
   input  regno_t           issue_rt_i,
   input  logic             wb_v_i,
   input  regno_t           wb_rt_i,
   input  logic             flush_i,
   output logic             issue_rdy_o,
   output logic [NREGS-1:0] busy_o,
   output regno_t           pending_o
);

   logic [NREGS-1:0] r_busy;
   regno_t           r_pending;
   logic [63:0]      w_busy_ext;
   logic [63:0]      w_busy_nxt;
   logic             w_wb_same;

   assign w_busy_ext = {{(64-NREGS){1'b0}}, r_busy};
   assign w_wb_same  = wb_v_i && (wb_rt_i == issue_rt_i);

   assign issue_rdy_o = issue_v_i &&
                        (!f_reg_ok(issue_rt_i) || !w_busy_ext[issue_rt_i] || w_wb_same);

   // Flush beats everything; otherwise an issue set overrides a same-register clear.
   always_comb begin
      w_busy_nxt = w_busy_ext;
      if (flush_i) begin
         w_busy_nxt = '0;
      end else begin
         if (wb_v_i && f_reg_ok(wb_rt_i))
            w_busy_nxt[wb_rt_i] = 1'b0;
         if (issue_rdy_o && f_reg_ok(issue_rt_i))
            w_busy_nxt[issue_rt_i] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy    <= '0;
         r_pending <= '0;
      end else begin
         r_busy    <= w_busy_nxt[NREGS-1:0];
         r_pending <= f_popcnt(w_busy_nxt[NREGS-1:0]);
      end
   end

   assign busy_o    = r_busy;
   assign pending_o = r_pending;

   logic w_unused;
   assign w_unused = ^w_busy_nxt[63:NREGS];

endmodule

// File: rtl/thor2022_regfile_wb.sv
// rtl/thor2022_regfile_wb.sv - Thor2022 architectural register file with write-back bypass
module thor2022_regfile_wb
   import Thor2022_pkg::*;
#(
   parameter int WID = 64
)(
   input  logic               clk_i,
   input  logic               rst_i,
   thor2022_regfile_wb_if.slave bus
);

   logic [WID-1:0]   r_regs [1:NREGS-1];
   logic             r_wb_err;
   logic [NREGS-1:0] w_busy_vec;
   logic [63:0]      w_busy_ext;
   regno_t           w_idx  [3];
   logic [WID-1:0]   w_data [3];
   logic             w_busy [3];
   logic             w_wb_ok;

   thor2022_scoreboard u_sb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .issue_v_i   (bus.issue_v_i),
      .issue_rt_i  (bus.issue_rt_i),
      .wb_v_i      (bus.wb_v_i),
      .wb_rt_i     (bus.wb_rt_i),
      .flush_i     (bus.flush_i),
      .issue_rdy_o (bus.issue_rdy_o),
      .busy_o      (w_busy_vec),
      .pending_o   (bus.pending_o)
   );

   assign w_busy_ext = {{(64-NREGS){1'b0}}, w_busy_vec};
   assign w_wb_ok    = bus.wb_v_i && f_reg_ok(bus.wb_rt_i);

   assign w_idx[0] = bus.ra_i;
   assign w_idx[1] = bus.rb_i;
   assign w_idx[2] = bus.rc_i;

   // A matching write-back is forwarded and hides the busy bit it is about to clear.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         w_data[p] = '0;
         w_busy[p] = 1'b0;
         if (f_reg_ok(w_idx[p])) begin
            if (bus.wb_v_i && (bus.wb_rt_i == w_idx[p])) begin
               w_data[p] = bus.wb_res_i;
            end else begin
               for (int i = 1; i < NREGS; i++)
                  if (w_idx[p] == regno_t'(i))
                     w_data[p] = r_regs[i];
               w_busy[p] = w_busy_ext[w_idx[p]];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 1; i < NREGS; i++)
            r_regs[i] <= '0;
         r_wb_err <= 1'b0;
      end else begin
         for (int i = 1; i < NREGS; i++)
            if (bus.wb_v_i && (bus.wb_rt_i == regno_t'(i)))
               r_regs[i] <= bus.wb_res_i;
         if (w_wb_ok && !w_busy_ext[bus.wb_rt_i])
            r_wb_err <= 1'b1;
      end
   end

   assign bus.ra_o      = w_data[0];
   assign bus.rb_o      = w_data[1];
   assign bus.rc_o      = w_data[2];
   assign bus.ra_busy_o = w_busy[0];
   assign bus.rb_busy_o = w_busy[1];
   assign bus.rc_busy_o = w_busy[2];
   assign bus.wb_err_o  = r_wb_err;

endmodule

// File: tb/tb_thor2022_regfile_wb.sv
// tb/tb_thor2022_regfile_wb.sv - scoreboard bench for the Thor2022 register file
module tb_thor2022_regfile_wb;
   import Thor2022_pkg::*;

   localparam int S_RA = 0, S_RB = 1, S_RC = 2, S_RAB = 3, S_RBB = 4, S_RCB = 5,
                  S_RDY = 6, S_PEND = 7, S_ERR = 8;

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb_q[$];

   thor2022_regfile_wb_if #(.WID(64)) bus ();

   thor2022_regfile_wb #(.WID(64)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] f_obs(input int sel);
      case (sel)
         S_RA:    return bus.ra_o;
         S_RB:    return bus.rb_o;
         S_RC:    return bus.rc_o;
         S_RAB:   return 64'(bus.ra_busy_o);
         S_RBB:   return 64'(bus.rb_busy_o);
         S_RCB:   return 64'(bus.rc_busy_o);
         S_RDY:   return 64'(bus.issue_rdy_o);
         S_PEND:  return 64'(bus.pending_o);
         default: return 64'(bus.wb_err_o);
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      #2;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, f_obs(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      bus.issue_v_i = 1'b0;
      bus.wb_v_i    = 1'b0;
      bus.flush_i   = 1'b0;
   endtask

   task automatic do_issue(input regno_t rt, input string tag);
      bus.issue_v_i  = 1'b1;
      bus.issue_rt_i = rt;
      push(tag, S_RDY, 64'd1);
      drain();
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.ra_i = '0; bus.rb_i = '0; bus.rc_i = '0;
      bus.issue_v_i = 1'b0; bus.issue_rt_i = '0;
      bus.wb_v_i = 1'b0; bus.wb_rt_i = '0; bus.wb_res_i = '0;
      bus.flush_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      bus.ra_i = 6'd0; bus.rb_i = 6'd5; bus.rc_i = 6'd47;
      push("rst_ra", S_RA, 0);   push("rst_rb", S_RB, 0);   push("rst_rc", S_RC, 0);
      push("rst_rab", S_RAB, 0); push("rst_rbb", S_RBB, 0); push("rst_rcb", S_RCB, 0);
      push("rst_pend", S_PEND, 0); push("rst_err", S_ERR, 0);
      push("rdy_idle", S_RDY, 0);
      drain();

      do_issue(6'd7, "iss7_rdy");
      bus.rb_i = 6'd7;
      push("r7_busy", S_RBB, 1); push("r7_pend", S_PEND, 1);
      drain();
      bus.wb_v_i = 1'b1; bus.wb_rt_i = 6'd7; bus.wb_res_i = 64'h1234;
      push("r7_bypass", S_RB, 64'h1234); push("r7_bypass_busy", S_RBB, 0);
      drain();
      tick();
      push("r7_stored", S_RB, 64'h1234); push("r7_pend0", S_PEND, 0);
      push("r7_busy0", S_RBB, 0); push("r7_err", S_ERR, 0);
      drain();

      do_issue(6'd44, "iss44_rdy");
      bus.issue_v_i = 1'b1; bus.issue_rt_i = 6'd44; bus.ra_i = 6'd44;
      push("waw_stall", S_RDY, 0); push("r44_busy", S_RAB, 1);
      drain();
      bus.wb_v_i = 1'b1; bus.wb_rt_i = 6'd44; bus.wb_res_i = 64'h4444_0000_0000_4444;
      push("waw_wb_rdy", S_RDY, 1); push("r44_bypass", S_RA, 64'h4444_0000_0000_4444);
      drain();
      tick();
      push("r44_stored", S_RA, 64'h4444_0000_0000_4444); push("r44_still_busy", S_RAB, 1);
      push("r44_pend", S_PEND, 1); push("r44_err", S_ERR, 0);
      drain();

      bus.ra_i = 6'd0; bus.rb_i = 6'd50;
      bus.wb_v_i = 1'b1; bus.wb_rt_i = 6'd0; bus.wb_res_i = 64'hFF;
      push("r0_bypass", S_RA, 0); push("oor_read", S_RB, 0); push("oor_busy", S_RBB, 0);
      drain();
      tick();
      push("r0_zero", S_RA, 0); push("r0_err", S_ERR, 0);
      drain();
      do_issue(6'd50, "iss50_rdy");
      push("iss50_pend", S_PEND, 1);
      drain();

      do_issue(6'd3, "iss3_rdy");
      do_issue(6'd41, "iss41_rdy");
      do_issue(6'd45, "iss45_rdy");
      push("pre_flush_pend", S_PEND, 4);
      drain();
      bus.flush_i = 1'b1;
      bus.wb_v_i = 1'b1; bus.wb_rt_i = 6'd3; bus.wb_res_i = 64'hAA;
      bus.issue_v_i = 1'b1; bus.issue_rt_i = 6'd9;
      tick();
      bus.ra_i = 6'd3; bus.rb_i = 6'd41; bus.rc_i = 6'd9;
      push("flush_r3", S_RA, 64'hAA); push("flush_r3_busy", S_RAB, 0);
      push("flush_r41_busy", S_RBB, 0); push("flush_r9_busy", S_RCB, 0);
      push("flush_pend", S_PEND, 0); push("flush_err", S_ERR, 0);
      drain();
      bus.rc_i = 6'd45;
      push("flush_r45_busy", S_RCB, 0);
      drain();

      bus.wb_v_i = 1'b1; bus.wb_rt_i = 6'd12; bus.wb_res_i = 64'hC0FFEE;
      tick();
      bus.ra_i = 6'd12;
      push("unsol_data", S_RA, 64'hC0FFEE); push("unsol_err", S_ERR, 1);
      drain();
      tick();
      push("unsol_err_held", S_ERR, 1);
      drain();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push("rst2_err", S_ERR, 0); push("rst2_r12", S_RA, 0); push("rst2_pend", S_PEND, 0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
